fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage: owns the program counter and fetches 32-bit instructions from instruction memory over a req/ack handshake.
- Presents `instruction`/`program_counter` to the decode/execute units (branch, ALU ops) with a valid/ready handshake.
- Consumes the redirect pair `load_new_program_counter`/`new_program_counter` driven by the branch and jump units.
- Flushes in-flight fetches on redirect and raises a fault on misaligned targets.

Parameters:
- XLEN, 32, data/address width.
- RESET_VECTOR, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst_n  in  1  asynchronous active-low reset.
- mem_req  out  1  instruction memory request.
- mem_addr  out  XLEN  fetch address; stable while mem_req is high and mem_ack is low.
- mem_ack  in  1  memory response; mem_rdata is valid in this cycle.
- mem_rdata  in  XLEN  fetched instruction word.
- instruction  out  XLEN  registered instruction for decode.
- program_counter  out  XLEN  address of `instruction` while instr_valid; otherwise the address being fetched.
- instr_valid  out  1  instruction/program_counter are valid.
- instr_ready  in  1  downstream consumes the instruction this cycle.
- load_new_program_counter  in  1  redirect strobe, sampled at posedge.
- new_program_counter  in  XLEN  redirect target.
- fetch_fault  out  1  misaligned fetch target is pending.

Behaviour:
- Reset (rst_n low, asynchronous) forces:
  - state=IDLE, pc=RESET_VECTOR, instruction=32'h0000_0013 (NOP).
  - instr_valid=0, mem_req=0, fetch_fault=0, drain_addr=0, fault_pending=0.
- Reset asserted mid-transaction abandons any outstanding request. Memory must tolerate the dropped mem_req.
- mem_req=1 in FETCH and DRAIN only.
- mem_addr is pc in FETCH and drain_addr in DRAIN.
- instr_valid=1 only in VALID. fetch_fault=1 only in FAULT.
- Redirect ("redir") = load_new_program_counter at a posedge. It is aligned iff new_program_counter[1:0]==0.
- Redirect has priority over mem_ack and instr_ready in every state.
- IDLE:
  - -> FETCH unconditionally on the next cycle.
  - First mem_req is in cycle 1 after reset release.
- FETCH:
  - mem_ack & !redir: instruction<=mem_rdata, -> VALID. Minimum latency from request to valid is 1 cycle.
  - mem_ack & redir: data discarded; pc<=target; -> FETCH if aligned, FAULT if not.
  - !mem_ack & redir: drain_addr<=pc, pc<=target, fault_pending<=misaligned, -> DRAIN. The outstanding request completes at the old address.
  - Otherwise: hold.
- DRAIN:
  - mem_req stays high at drain_addr.
  - redir while draining: pc<=target, fault_pending<=misaligned (last redirect wins).
  - On mem_ack: data discarded; -> FAULT if fault_pending (after any same-cycle update), else FETCH.
- VALID:
  - redir: pc<=target, -> FETCH/FAULT; the instruction is dropped even if instr_ready.
  - instr_ready & !redir: pc<=pc+4 (mod 2^XLEN, wraps 32'hFFFF_FFFC -> 0), -> FETCH.
  - Otherwise: hold instruction and program_counter stable.
- FAULT:
  - No memory traffic. program_counter = the misaligned target.
  - An aligned redir -> FETCH with pc<=target.
  - A misaligned redir updates pc and stays in FAULT.
- Throughput: at most one instruction per 2 cycles; no prefetch.

Decomposition:
- riscv_pkg holds:
  - XLEN.
  - the NOP constant (32'h0000_0013).
  - INSTR_BYTES=4.
  - fetch_state_t enum {IDLE, FETCH, VALID, DRAIN, FAULT}.
- Single module; no sub-module is warranted. The next-pc mux stays inline as an always_comb.

Test Plan:
- Reset, RESET_VECTOR=0, memory acks 1 cycle after req returning 32'h00A00093 -> mem_addr=0 in cycle 1; instr_valid=1, instruction=32'h00A00093, program_counter=0; with instr_ready, next mem_addr=4.
- instr_ready held low for 5 cycles in VALID -> instruction and program_counter stable, no mem_req. Release -> fetch at pc+4.
- Redirect to 32'h0000_0100 while FETCH of 0x8 is unacked, ack 3 cycles later -> mem_addr stays 0x8 until ack, data discarded, next request at 0x100, first valid pc=0x100.
- Redirect 32'h0000_0102 in VALID -> FAULT: fetch_fault=1, mem_req=0, program_counter=0x102. Then redirect to 0x200 -> fetch at 0x200, fetch_fault=0.
- Same-cycle mem_ack, instr_ready and redir in FETCH/VALID -> redirect wins, no instr_valid for discarded data.
- pc=32'hFFFF_FFFC consumed -> next mem_addr=0.
- rst_n asserted during DRAIN -> outputs return to reset values immediately (asynchronously).

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared constants and types for the instruction fetch stage.
package riscv_pkg;

    localparam int          XLEN        = 32;
    localparam logic [31:0] NOP         = 32'h0000_0013;
    localparam int          INSTR_BYTES = 4;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        VALID,
        DRAIN,
        FAULT
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over a req/ack handshake,
// hands instructions downstream over valid/ready, and follows redirects.
module fetch_unit #(
    parameter int                XLEN         = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0]   RESET_VECTOR = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            mem_req,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_ack,
    input  logic [XLEN-1:0] mem_rdata,
    output logic [XLEN-1:0] instruction,
    output logic [XLEN-1:0] program_counter,
    output logic            instr_valid,
    input  logic            instr_ready,
    input  logic            load_new_program_counter,
    input  logic [XLEN-1:0] new_program_counter,
    output logic            fetch_fault
);

    import riscv_pkg::*;

    fetch_state_t    state, state_next;
    logic [XLEN-1:0] pc, pc_next;
    logic [XLEN-1:0] drain_addr, drain_addr_next;
    logic            fault_pending, fault_pending_next;
    logic [XLEN-1:0] instruction_next;
    logic            redir;
    logic            misaligned;

    assign redir      = load_new_program_counter;
    assign misaligned = (new_program_counter[1:0] != 2'b00);

    // Outputs are decoded from state only; no input reaches an output combinationally.
    always_comb begin
        mem_req         = (state == FETCH) || (state == DRAIN);
        mem_addr        = (state == DRAIN) ? drain_addr : pc;
        // Outside VALID this is the address being fetched; in DRAIN that is
        // the old address still on the bus, not the redirect target.
        program_counter = mem_addr;
        instr_valid     = (state == VALID);
        fetch_fault     = (state == FAULT);
    end

    // Next-state, next-pc and capture logic; a redirect always wins.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_next         = state;
        pc_next            = pc;
        drain_addr_next    = drain_addr;
        fault_pending_next = fault_pending;
        instruction_next   = instruction;

        unique case (state)
            IDLE: begin
                state_next = FETCH;
                if (redir) begin
                    pc_next    = new_program_counter;
                    state_next = misaligned ? FAULT : FETCH;
                end
            end
            FETCH: begin
                if (redir && mem_ack) begin
                    pc_next    = new_program_counter;
                    state_next = misaligned ? FAULT : FETCH;
                end else if (redir) begin
                    // Request is still outstanding: let it finish at the old address.
                    drain_addr_next    = pc;
                    pc_next            = new_program_counter;
                    fault_pending_next = misaligned;
                    state_next         = DRAIN;
                end else if (mem_ack) begin
                    instruction_next = mem_rdata;
                    state_next       = VALID;
                end
            end
            DRAIN: begin
                if (redir) begin
                    pc_next            = new_program_counter;
                    fault_pending_next = misaligned;
                end
                if (mem_ack) begin
                    state_next = fault_pending_next ? FAULT : FETCH;
                end
            end
            VALID: begin
                if (redir) begin
                    pc_next    = new_program_counter;
                    state_next = misaligned ? FAULT : FETCH;
                end else if (instr_ready) begin
                    pc_next    = pc + XLEN'(INSTR_BYTES);
                    state_next = FETCH;
                end
            end
            FAULT: begin
                if (redir) begin
                    pc_next    = new_program_counter;
                    state_next = misaligned ? FAULT : FETCH;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            pc            <= RESET_VECTOR;
            drain_addr    <= '0;
            fault_pending <= 1'b0;
            instruction   <= XLEN'(NOP);
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all registers update together.
            state         <= state_next;
            pc            <= pc_next;
            drain_addr    <= drain_addr_next;
            fault_pending <= fault_pending_next;
            instruction   <= instruction_next;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] instruction;
    logic [31:0] program_counter;
    logic        instr_valid;
    logic        instr_ready;
    logic        load_new_program_counter;
    logic [31:0] new_program_counter;
    logic        fetch_fault;

    int passed = 0;
    int total  = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    fetch_unit #(.XLEN(32), .RESET_VECTOR(32'h0)) dut (
        .clk                      (clk),
        .rst_n                    (rst_n),
        .mem_req                  (mem_req),
        .mem_addr                 (mem_addr),
        .mem_ack                  (mem_ack),
        .mem_rdata                (mem_rdata),
        .instruction              (instruction),
        .program_counter          (program_counter),
        .instr_valid              (instr_valid),
        .instr_ready              (instr_ready),
        .load_new_program_counter (load_new_program_counter),
        .new_program_counter      (new_program_counter),
        .fetch_fault              (fetch_fault)
    );

    always #5 clk = ~clk;

    // Inputs applied for one cycle and the outputs expected before the next posedge.
    typedef struct {
        logic        ack;
        logic [31:0] rdata;
        logic        ready;
        logic        redir;
        logic [31:0] target;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        logic        e_fault;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic add(input logic ack, input logic [31:0] rdata, input logic ready,
                       input logic redir, input logic [31:0] target,
                       input logic e_req, input logic [31:0] e_addr, input logic e_valid,
                       input logic [31:0] e_instr, input logic [31:0] e_pc, input logic e_fault);
        vec_t v;
        v.ack = ack; v.rdata = rdata; v.ready = ready; v.redir = redir; v.target = target;
        v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
        v.e_instr = e_instr; v.e_pc = e_pc; v.e_fault = e_fault;
        vecs.push_back(v);
    endtask

    task automatic check_outputs(input string tag, input logic e_req, input logic [31:0] e_addr,
                                 input logic e_valid, input logic [31:0] e_instr,
                                 input logic [31:0] e_pc, input logic e_fault);
        check({tag, "_req"},   32'(mem_req),     32'(e_req));
        check({tag, "_valid"}, 32'(instr_valid), 32'(e_valid));
        check({tag, "_fault"}, 32'(fetch_fault), 32'(e_fault));
        check({tag, "_pc"},    program_counter,  e_pc);
        check({tag, "_instr"}, instruction,      e_instr);
        if (e_req) check({tag, "_addr"}, mem_addr, e_addr);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        mem_ack = 1'b0; mem_rdata = '0; instr_ready = 1'b0;
        load_new_program_counter = 1'b0; new_program_counter = '0;

        //   ack rdata          rdy redir target          req addr           vld instr          pc             flt
        add(0, 32'h0,          0, 0, 32'h0,          0, 32'h0,          0, NOP,          32'h0,          0); // r0 IDLE
        add(0, 32'h0,          0, 0, 32'h0,          1, 32'h0,          0, NOP,          32'h0,          0); // r1 FETCH 0
        add(1, 32'h00A0_0093,  0, 0, 32'h0,          1, 32'h0,          0, NOP,          32'h0,          0); // r2 ack
        add(0, 32'h0,          1, 0, 32'h0,          0, 32'h0,          1, 32'h00A0_0093, 32'h0,         0); // r3 VALID, consume
        add(1, 32'h1111_1111,  0, 0, 32'h0,          1, 32'h4,          0, 32'h00A0_0093, 32'h4,         0); // r4 FETCH 4
        for (int i = 0; i < 5; i++)
            add(0, 32'h0,      0, 0, 32'h0,          0, 32'h4,          1, 32'h1111_1111, 32'h4,         0); // r5-r9 stall
        add(0, 32'h0,          1, 0, 32'h0,          0, 32'h4,          1, 32'h1111_1111, 32'h4,         0); // r10 release
        add(0, 32'h0,          0, 1, 32'h100,        1, 32'h8,          0, 32'h1111_1111, 32'h8,         0); // r11 redir unacked
        add(0, 32'h0,          0, 0, 32'h0,          1, 32'h8,          0, 32'h1111_1111, 32'h8,         0); // r12 DRAIN
        add(0, 32'h0,          0, 0, 32'h0,          1, 32'h8,          0, 32'h1111_1111, 32'h8,         0); // r13 DRAIN
        add(1, 32'hDEAD_BEEF,  0, 0, 32'h0,          1, 32'h8,          0, 32'h1111_1111, 32'h8,         0); // r14 drain ack
        add(1, 32'h2222_2222,  0, 0, 32'h0,          1, 32'h100,        0, 32'h1111_1111, 32'h100,       0); // r15 FETCH 0x100
        add(0, 32'h0,          0, 1, 32'h102,        0, 32'h100,        1, 32'h2222_2222, 32'h100,       0); // r16 misaligned redir
        add(0, 32'h0,          0, 1, 32'h200,        0, 32'h102,        0, 32'h2222_2222, 32'h102,       1); // r17 FAULT
        add(1, 32'h3333_3333,  1, 1, 32'h300,        1, 32'h200,        0, 32'h2222_2222, 32'h200,       0); // r18 ack+ready+redir
        add(1, 32'h4444_4444,  0, 0, 32'h0,          1, 32'h300,        0, 32'h2222_2222, 32'h300,       0); // r19 FETCH 0x300
        add(0, 32'h0,          1, 1, 32'hFFFF_FFFC,  0, 32'h300,        1, 32'h4444_4444, 32'h300,       0); // r20 ready+redir
        add(1, 32'h5555_5555,  0, 0, 32'h0,          1, 32'hFFFF_FFFC,  0, 32'h4444_4444, 32'hFFFF_FFFC, 0); // r21 FETCH top
        add(0, 32'h0,          1, 0, 32'h0,          0, 32'hFFFF_FFFC,  1, 32'h5555_5555, 32'hFFFF_FFFC, 0); // r22 consume top
        add(0, 32'h0,          0, 1, 32'h401,        1, 32'h0,          0, 32'h5555_5555, 32'h0,         0); // r23 wrapped, redir bad
        add(0, 32'h0,          0, 1, 32'h404,        1, 32'h0,          0, 32'h5555_5555, 32'h0,         0); // r24 DRAIN redir good
        add(1, 32'h0,          0, 1, 32'h406,        1, 32'h0,          0, 32'h5555_5555, 32'h0,         0); // r25 ack+redir bad
        add(0, 32'h0,          0, 1, 32'h503,        0, 32'h406,        0, 32'h5555_5555, 32'h406,       1); // r26 FAULT, bad redir
        add(0, 32'h0,          0, 1, 32'h600,        0, 32'h503,        0, 32'h5555_5555, 32'h503,       1); // r27 FAULT, good redir
        add(0, 32'h0,          0, 1, 32'h700,        1, 32'h600,        0, 32'h5555_5555, 32'h600,       0); // r28 FETCH, redir

        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            mem_ack                  = vecs[i].ack;
            mem_rdata                = vecs[i].rdata;
            instr_ready              = vecs[i].ready;
            load_new_program_counter = vecs[i].redir;
            new_program_counter      = vecs[i].target;
            #1;
            check_outputs($sformatf("r%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_valid,
                          vecs[i].e_instr, vecs[i].e_pc, vecs[i].e_fault);
            @(negedge clk);
        end

        // Asynchronous reset while draining: outputs must drop without a clock edge.
        mem_ack = 1'b0; instr_ready = 1'b0; load_new_program_counter = 1'b0;
        #1;
        check_outputs("drain_pre", 1'b1, 32'h600, 1'b0, 32'h5555_5555, 32'h600, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        check_outputs("async_rst", 1'b0, 32'h0, 1'b0, NOP, 32'h0, 1'b0);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_outputs("post_rst_idle", 1'b0, 32'h0, 1'b0, NOP, 32'h0, 1'b0);
        @(negedge clk);
        #1;
        check_outputs("post_rst_fetch", 1'b1, 32'h0, 1'b0, NOP, 32'h0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
